// File: rtl/arr_stim_gen.sv
// Stimulus sequencer for the per-length arr check stage: drives LFSR-derived sig/rfr
// pairs with optional single-vector corruption, strobes check, and counts injected mismatches.
module arr_stim_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_VECS = 16,
    parameter logic [31:0] SEED     = 32'h0000_0001,
    parameter int unsigned GAP      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             err_en,
    input  logic [15:0]      err_index,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rfr,
    output logic             check,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_idx,
    output logic [15:0]      mismatches
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECS - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d, lfsr_next;
    logic [WIDTH-1:0]  sig_q, sig_d, rfr_q, rfr_d, mapped;
    logic              check_q, check_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       vec_idx_q, vec_idx_d;
    logic [15:0]       mism_q, mism_d;
    logic              err_en_q, err_en_d;
    logic [15:0]       err_idx_q, err_idx_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              advance;

    // LFSR word repeated across the output width, keeping the LSBs.
    function automatic logic [WIDTH-1:0] map_lfsr(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = v[i % 32];
        end
        return r;
    endfunction

    always_comb begin
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
        mapped    = map_lfsr(lfsr_next);
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        sig_d     = sig_q;
        rfr_d     = rfr_q;
        check_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        vec_idx_d = vec_idx_q;
        mism_d    = mism_q;
        err_en_d  = err_en_q;
        err_idx_d = err_idx_q;
        gap_cnt_d = gap_cnt_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    lfsr_d    = SEED;
                    vec_idx_d = '0;
                    mism_d    = '0;
                    err_en_d  = err_en;
                    err_idx_d = err_index;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
            end
            S_LOAD: begin
                lfsr_d  = lfsr_next;
                sig_d   = mapped;
                rfr_d   = (err_en_q && (vec_idx_q == err_idx_q)) ? (mapped ^ WIDTH'(1)) : mapped;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                check_d = 1'b1;
                if ((sig_q != rfr_q) && (mism_q != 16'hFFFF)) begin
                    mism_d = mism_q + 16'd1;
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                gap_cnt_d = '0;
                if (GAP == 0) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared end-of-vector step, reached from GAP or directly from CHECK when GAP is 0.
        if (advance) begin
            if (vec_idx_q == LAST_VEC) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                vec_idx_d = vec_idx_q + 16'd1;
                state_d   = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            sig_q     <= '0;
            rfr_q     <= '0;
            check_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vec_idx_q <= '0;
            mism_q    <= '0;
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            sig_q     <= sig_d;
            rfr_q     <= rfr_d;
            check_q   <= check_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            vec_idx_q <= vec_idx_d;
            mism_q    <= mism_d;
            err_en_q  <= err_en_d;
            err_idx_q <= err_idx_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign sig        = sig_q;
    assign rfr        = rfr_q;
    assign check      = check_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign vec_idx    = vec_idx_q;
    assign mismatches = mism_q;

endmodule

// File: doc/arr_stim_gen.md
Name: arr_stim_gen

Overview:
- Stimulus sequencer that sits directly upstream of the per-length `arr` check stage in the VPI variable-access regression.
- Each vector: drives a pseudo-random `sig` and a reference `rfr` (equal, or deliberately corrupted), then pulses `check` so the downstream stage compares them.
- Counts the mismatches it injected, so the bench can cross-check against downstream `$stop` or VPI readback.
- Runs a fixed number of vectors per `start`, then holds `done`.

Parameters:
- WIDTH, 8, width of `sig`/`rfr`; legal 1..128.
- NUM_VECS, 16, vectors per run; legal 1..65535.
- SEED, 32'h0000_0001, LFSR seed; must be nonzero.
- GAP, 2, idle cycles after each check pulse; legal 0..255.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin run; sampled only in IDLE or DONE.
- err_en  in  1  enable single-vector corruption; sampled with `start`.
- err_index  in  16  vector index to corrupt; sampled with `start`.
- sig  out  WIDTH  stimulus value.
- rfr  out  WIDTH  reference value.
- check  out  1  one-cycle compare strobe to downstream.
- busy  out  1  high while the run is in progress.
- done  out  1  high from end of run until next accepted `start`.
- vec_idx  out  16  index of the current or last vector.
- mismatches  out  16  count of vectors driven with `sig != rfr`.

Behaviour:
- Reset (synchronous, active-high, any state including mid-run):
  - `sig`, `rfr`, `check`, `busy`, `done`, `vec_idx`, `mismatches` all go to 0.
  - FSM goes to IDLE; LFSR goes to SEED; latched `err_en` goes to 0.
- LFSR: 32-bit Galois, right shift.
  - `next = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 0)`.
  - Steps exactly once per LOAD.
- Width mapping: `sig` is the LFSR replicated ceil(WIDTH/32) times and truncated to the WIDTH LSBs.
- All outputs are registered.
- FSM states: IDLE, LOAD, SETTLE, CHECK, GAP, DONE.
  - IDLE/DONE + `start` → LOAD.
    - Reseed LFSR to SEED; `vec_idx` ← 0; `mismatches` ← 0.
    - Latch `err_en`/`err_index`; `busy` ← 1; `done` ← 0.
  - LOAD → SETTLE.
    - `lfsr` ← `next`; `sig` ← map(`next`).
    - `rfr` ← map(`next`) ^ 1 if latched `err_en` and `vec_idx == err_index`; else `rfr` ← map(`next`).
  - SETTLE → CHECK.
    - `check` ← 1.
    - `mismatches` ← `mismatches` + 1 if `sig != rfr`; saturates at 16'hFFFF.
  - CHECK → GAP (or → next step directly when GAP = 0); `check` ← 0.
  - GAP: count GAP cycles. On exit:
    - if `vec_idx == NUM_VECS-1`: → DONE, `busy` ← 0, `done` ← 1, `vec_idx` held;
    - else: `vec_idx` ← `vec_idx` + 1, → LOAD.
- Timing:
  - `start` sampled at edge N → `sig` valid after edge N+1 → `check` high for the cycle after edge N+2.
  - Vector period is 3+GAP cycles.
  - `done` rises at edge N + NUM_VECS·(3+GAP).
- Ignored/held cases:
  - `start` is ignored while `busy`.
  - `start` held high in DONE immediately restarts a run.
  - `err_index` ≥ NUM_VECS means no corruption.
- `sig`/`rfr` hold their last values in GAP, IDLE and DONE; they are stable whenever `check` = 1.
- `check` is never high for two consecutive cycles.

Test Plan:
1. WIDTH=8, SEED=1, GAP=2, NUM_VECS=3, `start` at edge 10 → `sig`/`rfr` = 8'h03, 8'h02, 8'h01; `check` high after edges 12, 17, 22; `done` at edge 25; `mismatches` = 0.
2. Same, with `err_en`=1 and `err_index`=1 → vector 1 has `sig`=8'h02, `rfr`=8'h03; final `mismatches` = 1; vectors 0 and 2 match.
3. WIDTH=40, SEED=1, NUM_VECS=1 → `sig` = 40'h03_8020_0003 and `rfr` equal.
4. Reset asserted in CHECK of vector 5 (NUM_VECS=16) → next cycle all outputs 0 and IDLE. A new `start` then reproduces vector 0 = 8'h03 (reseed verified).
5. `start` pulsed mid-run at vector 2 → ignored; run completes normally at `vec_idx` 15 with `done` = 1. A second `start` in DONE clears `done` and `mismatches` and restarts.
6. GAP=0, NUM_VECS=4 → `check` period of 3 cycles, never back-to-back; `done` at edge N+12.
